cnn_mem_arbiter: RTL

CNN_MEM_ARBITER -- requirements
Module: cnn_mem_arbiter

---
 rtl/cnn_mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cnn_mem_arbiter.sv
// Round-robin arbiter for the CNN memory port (loader read, conv write, prev read).
// Grants are registered one cycle after a sampled request; memory signals follow the live grant & req.
module cnn_mem_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_load,
    input  logic [15:0] addr_load,
    input  logic        req_write,
    input  logic [15:0] addr_write,
    input  logic [15:0] wdata,
    input  logic        req_prev,
    input  logic [15:0] addr_prev,
    output logic        gnt_load,
    output logic        gnt_write,
    output logic        gnt_prev,
    output logic [15:0] mem_address,
    output logic        mem_write_enable,
    output logic [15:0] mem_data_in,
    output logic [1:0]  owner,
    output logic        busy
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_LOAD  = 2'd1;
    localparam logic [1:0] OWN_WRITE = 2'd2;
    localparam logic [1:0] OWN_PREV  = 2'd3;
    localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_owner, w_owner_nxt;
    logic [1:0] r_last,  w_last_nxt;
    logic [7:0] r_cnt,   w_cnt_nxt;
    logic [1:0] w_winner;
    logic       w_owner_req;
    logic       w_other_req;
    logic       w_act_load, w_act_write, w_act_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_owner <= OWN_NONE;
            r_last  <= OWN_PREV;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Search starts at the requester after the previous owner.
    always_comb begin
        w_winner = OWN_NONE;
        case (r_last)
            OWN_LOAD: begin
                if      (req_write) w_winner = OWN_WRITE;
                else if (req_prev)  w_winner = OWN_PREV;
                else if (req_load)  w_winner = OWN_LOAD;
            end
            OWN_WRITE: begin
                if      (req_prev)  w_winner = OWN_PREV;
                else if (req_load)  w_winner = OWN_LOAD;
                else if (req_write) w_winner = OWN_WRITE;
            end
            default: begin
                if      (req_load)  w_winner = OWN_LOAD;
                else if (req_write) w_winner = OWN_WRITE;
                else if (req_prev)  w_winner = OWN_PREV;
            end
        endcase
    end

    always_comb begin
        w_owner_req = 1'b0;
        case (r_owner)
            OWN_LOAD:  w_owner_req = req_load;
            OWN_WRITE: w_owner_req = req_write;
            OWN_PREV:  w_owner_req = req_prev;
            default:   w_owner_req = 1'b0;
        endcase
        w_other_req = (req_load  && (r_owner != OWN_LOAD))  ||
                      (req_write && (r_owner != OWN_WRITE)) ||
                      (req_prev  && (r_owner != OWN_PREV));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_winner != OWN_NONE) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_winner;
                    w_last_nxt  = w_winner;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_GRANT: begin
                if (!w_owner_req) begin
                    w_state_nxt = S_IDLE;
                    w_owner_nxt = OWN_NONE;
                end else begin
                    if (r_cnt < BURST_MAX) w_cnt_nxt = r_cnt + 8'd1;
                    // This cycle brings the count to the limit (or it already sits there).
                    if ((r_cnt >= BURST_LAST) && w_other_req) begin
                        w_state_nxt = S_IDLE;
                        w_owner_nxt = OWN_NONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_owner_nxt = OWN_NONE;
            end
        endcase
    end

    assign gnt_load  = (r_owner == OWN_LOAD);
    assign gnt_write = (r_owner == OWN_WRITE);
    assign gnt_prev  = (r_owner == OWN_PREV);
    assign owner     = r_owner;
    assign busy      = gnt_load | gnt_write | gnt_prev;

    assign w_act_load  = gnt_load  & req_load;
    assign w_act_write = gnt_write & req_write;
    assign w_act_prev  = gnt_prev  & req_prev;

    assign mem_address      = w_act_load  ? addr_load  :
                              w_act_write ? addr_write :
                              w_act_prev  ? addr_prev  : 16'd0;
    assign mem_write_enable = w_act_write;
    assign mem_data_in      = w_act_write ? wdata : 16'd0;

endmodule
